fixed_to_float_norm: RTL and testbench
======================================

FIXED_TO_FLOAT_NORM -- requirements
Module: fixed_to_float_norm

Interface
REQ-001 The block SHALL have parameter W, default 22, which is the signed fixed-point input width (legal range 2..24).
REQ-002 The block SHALL have parameter FRAC_BITS, default 20, which is the number of fractional bits in the input (Q2.20 by default, matching cordic cos_out).
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-005 Port enable SHALL be an input, 1 bit wide: start request, sampled only in IDLE.
REQ-006 Port data SHALL be an input, W bits wide: two's-complement fixed-point operand.
REQ-007 Port result SHALL be an output, 32 bits wide: IEEE-754 single-precision result, registered.
REQ-008 Port done SHALL be an output, 1 bit wide: one-cycle completion pulse, coincident with result update.

Function
REQ-009 The FSM SHALL have states IDLE, NORM and PACK.
- IDLE→NORM: on an edge with enable=1 and data≠0.
- IDLE→PACK: on an edge with enable=1 and data=0.
- NORM→PACK: when the normalization condition holds.
- PACK→IDLE: always.
REQ-010 On capture (IDLE, enable=1), the block SHALL:
- register sign=data[W-1];
- register mag=|data| as W-bit unsigned (−2^(W-1) gives mag=2^(W-1), with no overflow);
- set shift count k=0.
REQ-011 In NORM, each edge SHALL do one of the following:
- if mag[W-1]=1, go to PACK;
- otherwise shift mag left by 1 and increment k.
REQ-012 On the PACK edge, the block SHALL write result as follows:
- result[31]=sign;
- result[30:23]=127+(W-1-FRAC_BITS)-k;
- result[22:0]=mag[W-2:0] left-aligned, zero-padded.
REQ-013 The conversion SHALL be exact; no rounding is required because W≤24.
REQ-014 Zero input SHALL produce result=32'h00000000 (+0.0); −0 SHALL never be produced.
REQ-015 The PACK edge SHALL also set done=1; done SHALL clear on the next edge.
REQ-016 result SHALL hold its value between completions.
REQ-017 Latency SHALL be as follows:
- nonzero input: done is high after edge E0+k+2, where E0 is the capture edge and k is the leading zeros of mag in the W-bit field;
- zero input: done is high after edge E0+1.
REQ-018 enable and data SHALL be ignored outside IDLE; the operand is captured only at E0.
REQ-019 If enable is still high in the cycle after PACK (state IDLE), a new conversion SHALL start.
- This gives back-to-back operation with a level-held enable.

Reset
REQ-020 Asserting reset SHALL immediately force state=IDLE, result=0, done=0, sign=0, mag=0 and k=0, without waiting for clk.
REQ-021 Reset during NORM or PACK SHALL abort the conversion with no done pulse; result SHALL read 0.
REQ-022 After reset deasserts, the first edge with enable=1 SHALL be treated as a fresh E0.

Configuration
REQ-023 The macro FX2F_FAST_NORM_EN, when defined, SHALL change NORM as follows:
- if mag[W-1:W-4]=0, shift left by 4 and add 4 to k in one edge;
- otherwise apply REQ-011.
REQ-024 With FX2F_FAST_NORM_EN defined, nonzero latency SHALL be E0+floor(k/4)+(k mod 4)+2; results SHALL be identical.
REQ-025 Without FX2F_FAST_NORM_EN, only single-bit shifts SHALL exist and REQ-017 latency SHALL apply.

Verification (defaults W=22, FRAC_BITS=20)
REQ-026 data=22'h100000 (+1.0), enable pulse → result=32'h3F800000, done after E0+3, single-cycle done.
REQ-027 data=22'h300000 (−1.0) → 32'hBF800000 at E0+3; data=22'h200000 (−2.0) → 32'hC0000000 at E0+2.
REQ-028 data=22'h000001 → 32'h35800000; done at E0+23 without the macro, at E0+8 with FX2F_FAST_NORM_EN.
REQ-029 data=0 → 32'h00000000 at E0+1; then data=22'h0C0000 (0.75) with enable held high → 32'h3F400000 on the following conversion, with a back-to-back restart per REQ-019.
REQ-030 Start data=22'h000001, assert reset 5 edges after E0 → done never pulses, result=0; after release, data=22'h100000 → 32'h3F800000.
REQ-031 Change data and toggle enable during NORM → result reflects only the operand captured at E0.

Source files
------------

// File: rtl/fixed_to_float_norm.sv
// fixed_to_float_norm
//
// Converts a signed two's-complement fixed-point operand (W bits, FRAC_BITS
// fractional bits) into an IEEE-754 single-precision value. The magnitude is
// normalised one bit per clock until its MSB is set, then packed. The
// conversion is exact because W <= 24 fits the 24-bit significand.
//
// Optional build macro:
//   FX2F_FAST_NORM_EN - while the top four magnitude bits are all zero,
//                       normalisation shifts by four in a single clock.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - asynchronous active-high reset
//   enable - start request, sampled only while idle
//   data   - W-bit two's-complement fixed-point operand
//   result - registered IEEE-754 single-precision result
//   done   - one-cycle pulse coincident with a result update
module fixed_to_float_norm #(
  parameter int W         = 22,
  parameter int FRAC_BITS = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] data,
  output logic [31:0]  result,
  output logic         done
);

  localparam int            KW       = $clog2(W);
  localparam logic [7:0]    EXP_BASE = 8'(127 + W - 1 - FRAC_BITS);
  localparam logic [W-1:0]  ZERO_W   = '0;
  localparam int            SHIFT4   = (W >= 4) ? (W - 4) : 0;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    PACK
  } state_t;

  state_t        state_q, state_d;
  logic          sign_q, sign_d;
  logic [W-1:0]  mag_q, mag_d;
  logic [KW-1:0] k_q, k_d;
  logic [31:0]   result_q, result_d;
  logic          done_q, done_d;
  logic [22:0]   mant;
  logic          topNibbleZero;

  // State and datapath registers; reset clears everything at once so an
  // aborted conversion never produces a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      k_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      k_q      <= k_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    k_d      = k_q;
    result_d = result_q;
    done_d   = 1'b0;

    // Mantissa drops the implicit leading one and left-aligns the remaining
    // W-1 bits in the 23-bit field.
    mant          = 23'(mag_q[W-2:0]) << (24 - W);
    topNibbleZero = ((mag_q >> SHIFT4) == ZERO_W);

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          sign_d = data[W-1];
          // Negating the most negative value wraps to 2^(W-1), which is the
          // correct unsigned magnitude.
          mag_d  = data[W-1] ? (ZERO_W - data) : data;
          k_d    = '0;
          state_d = (data == ZERO_W) ? PACK : NORM;
        end
      end

      NORM: begin
        if (mag_q[W-1]) begin
          state_d = PACK;
`ifdef FX2F_FAST_NORM_EN
        end else if ((W >= 4) && topNibbleZero) begin
          mag_d = mag_q << 4;
          k_d   = k_q + KW'(4);
`endif
        end else begin
          mag_d = mag_q << 1;
          k_d   = k_q + KW'(1);
        end
      end

      PACK: begin
        state_d = IDLE;
        done_d  = 1'b1;
        // Zero has no leading one; force +0.0 regardless of exponent math.
        if (mag_q == ZERO_W) begin
          result_d = 32'h0000_0000;
        end else begin
          result_d = {sign_q, EXP_BASE - 8'(k_q), mant};
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fixed_to_float_norm.sv
// tb_fixed_to_float_norm
//
// Scoreboard bench: the driver pushes the expected result and the clock
// count at which done must appear; a monitor pops and compares on each done.
module tb_fixed_to_float_norm;

  localparam int W         = 22;
  localparam int FRAC_BITS = 20;

  typedef struct {
    logic [31:0] res;
    int          doneEdge;
    logic [W-1:0] operand;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [W-1:0] data;
  logic [31:0]  result;
  logic         done;

  int   cyc;
  int   compareCount;
  int   mismatchCount;
  exp_t sb[$];

  fixed_to_float_norm #(
    .W(W),
    .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .data(data),
    .result(result),
    .done(done)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count of rising edges seen so far.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: value = data / 2^FRAC_BITS, expressed directly as IEEE-754
  // from the position of the highest set bit of |value|.
  function automatic void refConvert(input logic [W-1:0] d,
                                     output logic [31:0] res,
                                     output int lat);
    longint sv, av;
    int     p, k;
    logic [7:0]  e;
    logic [22:0] m;
    sv = longint'($signed(d));
    av = (sv < 0) ? -sv : sv;
    if (av == 0) begin
      res = 32'h0;
      lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 40; i++) if ((av >> i) & 1) p = i;
    e = 8'(127 + p - FRAC_BITS);
    m = 23'((av - (longint'(1) << p)) << (23 - p));
    res = {(sv < 0), e, m};
    k = (W - 1) - p;
`ifdef FX2F_FAST_NORM_EN
    lat = (k / 4) + (k % 4) + 2;
`else
    lat = k + 2;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  // Called at a falling edge while the DUT is idle. Issues one conversion,
  // scrambles enable/data while busy, and returns at the falling edge
  // following the done edge with enable low.
  task automatic applyStimulus(input logic [W-1:0] val);
    exp_t ex;
    int   lat;
    refConvert(val, ex.res, lat);
    ex.operand  = val;
    data        = val;
    enable      = 1'b1;
    ex.doneEdge = cyc + 1 + lat;
    sb.push_back(ex);
    forever begin
      @(negedge clk);
      if (cyc >= ex.doneEdge) break;
      data   = W'($urandom);
      enable = 1'($urandom);
    end
    enable = 1'b0;
    data   = W'($urandom);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t ex;
        ex = sb.pop_front();
        checkOutput($sformatf("result[%h]", ex.operand), result, ex.res);
        checkOutput($sformatf("done_edge[%h]", ex.operand), 32'(cyc), 32'(ex.doneEdge));
      end
    end
  end

  initial begin
    logic [W-1:0] rv;
    compareCount  = 0;
    mismatchCount = 0;
    reset  = 1'b1;
    enable = 1'b0;
    data   = '0;
    #1;
    checkOutput("reset_result", result, 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed: +1.0, -1.0, -2.0, smallest positive, largest positive, -1 LSB
    applyStimulus(W'(22'h100000)); @(negedge clk);
    applyStimulus(W'(22'h300000)); @(negedge clk);
    applyStimulus(W'(22'h200000)); @(negedge clk);
    applyStimulus(W'(22'h000001)); @(negedge clk);
    applyStimulus(W'(22'h1FFFFF)); @(negedge clk);
    applyStimulus(W'(22'h3FFFFF)); @(negedge clk);
    // Zero, then 0.75 back-to-back with enable held
    applyStimulus(W'(22'h000000));
    applyStimulus(W'(22'h0C0000));
    @(negedge clk);

    // Abort: reset five edges into a long conversion
    data = W'(22'h000001);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    data   = W'(22'h2AAAAA);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_result", result, 32'h0);
    checkOutput("abort_done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("post_abort_result", result, 32'h0);
    @(negedge clk);
    applyStimulus(W'(22'h100000)); @(negedge clk);

    // Randomised operands with varied leading-zero counts and gaps
    for (int i = 0; i < 40; i++) begin
      rv = W'($urandom) >> $urandom_range(0, W);
      if ($urandom_range(0, 1) == 1) rv = ZERO_W_FN() - rv;
      applyStimulus(rv);
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  function automatic logic [W-1:0] ZERO_W_FN();
    return '0;
  endfunction

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at edge %0d, expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
